// File: rtl/uart_tx_ctrl_if.sv
// Bundle between the upstream requester / UART TX output mux and uart_tx_ctrl.
//
// Handshake: Data_Valid is the request and ~busy is the ready. A byte is
// transferred on a rising CLK edge where Data_Valid=1 and busy=0; P_DATA,
// PAR_EN and PAR_TYP are captured on that same edge. A request seen while
// busy=1 is dropped, not held, so the requester keeps Data_Valid high (or
// pulses it again) until it observes the transfer.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;
    logic [2:0]            state_dbg;   // raw FSM state register, for checkers

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, par_bit, busy, state_dbg
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, par_bit, busy, state_dbg
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencing controller. One CLK cycle is one bit period.
// Frame: start -> DATA_WIDTH data bits (LSB first) -> optional parity -> stop.
// mux_sel/busy are pure decodes of the state register (no input-to-output path).
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    logic [2:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  par_en_q, par_en_d;
    // PAR_TYP only matters at accept, where it is folded into par_bit_q,
    // so it needs no register of its own.
    logic                  par_bit_q, par_bit_d;

    logic [1:0]            mux_sel_w;
    logic                  busy_w;

    // Next-state, shift register, bit counter and parity latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    shift_d   = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                    cnt_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // Clear instead of incrementing so the counter never wraps.
                    cnt_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                // Unused encodings fall back to IDLE on the next edge.
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns the line to idle-high at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Moore decode of mux select and busy from the state register alone.
    always_comb begin
        mux_sel_w = SEL_STOP;
        busy_w    = 1'b0;
        case (state_q)
            S_START:  begin mux_sel_w = SEL_START;  busy_w = 1'b1; end
            S_DATA:   begin mux_sel_w = SEL_DATA;   busy_w = 1'b1; end
            S_PARITY: begin mux_sel_w = SEL_PARITY; busy_w = 1'b1; end
            S_STOP:   begin mux_sel_w = SEL_STOP;   busy_w = 1'b1; end
            default:  begin mux_sel_w = SEL_STOP;   busy_w = 1'b0; end
        endcase
    end

    assign bus.mux_sel   = mux_sel_w;
    assign bus.busy      = busy_w;
    assign bus.ser_data  = shift_q[0];
    assign bus.par_bit   = par_bit_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: reset checks, a table of fixed frames, a held
// Data_Valid sequence, a mid-frame reset, and a random phase, all checked
// cycle by cycle against a frame-level reference model.
module tb_uart_tx_ctrl;
    localparam int W = 8;

    logic CLK;
    logic RST;

    uart_tx_ctrl_if #(.DATA_WIDTH(W)) bus();

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected per-cycle view of the line: {mux_sel, tx line level, busy}
    typedef struct packed {
        logic [1:0] mux;
        logic       line;
        logic       busy;
    } cyc_t;

    localparam cyc_t IDLE_C = '{mux: 2'b01, line: 1'b1, busy: 1'b0};

    cyc_t exp_q[$];
    cyc_t cur;
    logic par_m;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         pe;
        logic         pt;
        int           len;
        logic [10:0]  line;   // bit j = expected TX level in frame cycle j
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX line as the output mux would build it.
    function automatic logic line_now();
        case (bus.mux_sel)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return bus.ser_data;
            default: return bus.par_bit;
        endcase
    endfunction

    // Reference model: an accepted byte becomes a list of line cycles.
    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        par_m = (^d) ^ pt;
        exp_q.push_back('{mux: 2'b00, line: 1'b0, busy: 1'b1});
        for (int i = 0; i < W; i++)
            exp_q.push_back('{mux: 2'b10, line: d[i], busy: 1'b1});
        if (pe)
            exp_q.push_back('{mux: 2'b11, line: par_m, busy: 1'b1});
        exp_q.push_back('{mux: 2'b01, line: 1'b1, busy: 1'b1});
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur   = IDLE_C;
        par_m = 1'b0;
    endtask

    // Driver + scoreboard: advance one clock and compare against the model.
    task automatic step();
        if (!RST && !cur.busy && bus.Data_Valid)
            push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
        @(posedge CLK);
        #1;
        if (RST)
            model_reset();
        else if (exp_q.size() > 0)
            cur = exp_q.pop_front();
        else
            cur = IDLE_C;
        chk("mux_sel", 32'(bus.mux_sel), 32'(cur.mux));
        chk("busy",    32'(bus.busy),    32'(cur.busy));
        chk("tx_line", 32'(line_now()),  32'(cur.line));
        chk("par_bit", 32'(bus.par_bit), 32'(par_m));
    endtask

    logic [W-1:0] f1, f2;
    int           starts, idles;
    logic         ln;

    initial begin
        // Frame patterns: {stop, parity, data[7:0], start}, or {stop, data, start}.
        vecs[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, len: 11, line: 11'b10101001010};
        vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, len: 11, line: 11'b11101001010};
        vecs[2] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, len: 11, line: 11'b11000000000};
        vecs[3] = '{data: 8'h3C, pe: 1'b0, pt: 1'b0, len: 10, line: 11'b01001111000};
        vecs[4] = '{data: 8'hFF, pe: 1'b1, pt: 1'b0, len: 11, line: 11'b10111111110};
        vecs[5] = '{data: 8'h81, pe: 1'b0, pt: 1'b1, len: 10, line: 11'b01100000010};

        RST            = 1'b1;
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = '0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        model_reset();

        // Reset state, before any clock edge.
        #3;
        chk("rst_mux_sel",  32'(bus.mux_sel),  32'h1);
        chk("rst_busy",     32'(bus.busy),     32'h0);
        chk("rst_ser_data", 32'(bus.ser_data), 32'h0);
        chk("rst_par_bit",  32'(bus.par_bit),  32'h0);
        step();
        step();
        RST = 1'b0;

        // Idle for 10 cycles with no request.
        for (int i = 0; i < 10; i++) step();

        // Fixed frames; inputs are scrambled right after accept.
        for (int v = 0; v < 6; v++) begin
            bus.P_DATA     = vecs[v].data;
            bus.PAR_EN     = vecs[v].pe;
            bus.PAR_TYP    = vecs[v].pt;
            bus.Data_Valid = 1'b1;
            step();
            bus.Data_Valid = 1'b0;
            bus.P_DATA     = ~vecs[v].data;
            bus.PAR_EN     = ~vecs[v].pe;
            bus.PAR_TYP    = ~vecs[v].pt;
            for (int j = 0; j < vecs[v].len; j++) begin
                if (j > 0) step();
                chk("vec_line", 32'(line_now()), 32'(vecs[v].line[j]));
                chk("vec_busy", 32'(bus.busy), 32'h1);
                if (!vecs[v].pe)
                    chk("vec_no_par_sel", 32'(bus.mux_sel == 2'b11), 32'h0);
            end
            step();
            chk("vec_idle_after", 32'(bus.busy), 32'h0);
        end

        // Data_Valid held high; P_DATA changes during frame 1.
        bus.P_DATA     = 8'h5A;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        starts = 0;
        idles  = 0;
        f1     = '0;
        f2     = '0;
        for (int c = 0; c < 23; c++) begin
            if (c == 4) bus.P_DATA = 8'hFF;
            step();
            ln = line_now();
            if (bus.mux_sel == 2'b00) starts++;
            if (!bus.busy) idles++;
            if (c >= 1 && c <= 8)   f1[c - 1]  = ln;
            if (c >= 13 && c <= 20) f2[c - 13] = ln;
        end
        bus.Data_Valid = 1'b0;
        chk("held_frame1_data", 32'(f1), 32'h5A);
        chk("held_frame2_data", 32'(f2), 32'hFF);
        chk("held_start_count", 32'(starts), 32'd2);
        chk("held_idle_gap",    32'(idles),  32'd1);
        for (int i = 0; i < 3; i++) step();

        // Reset during DATA cycle 3.
        bus.P_DATA     = 8'hA5;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_in_data", 32'(bus.mux_sel), 32'h2);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk("async_rst_mux_sel", 32'(bus.mux_sel), 32'h1);
        chk("async_rst_busy",    32'(bus.busy),    32'h0);
        chk("async_rst_par_bit", 32'(bus.par_bit), 32'h0);
        step();
        step();
        RST = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Random requests, data and configuration every cycle.
        for (int i = 0; i < 600; i++) begin
            bus.Data_Valid = ($urandom_range(0, 3) == 0);
            bus.P_DATA     = W'($urandom);
            bus.PAR_EN     = 1'($urandom_range(0, 1));
            bus.PAR_TYP    = 1'($urandom_range(0, 1));
            step();
        end
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 14; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
